ctrl_fsm_mc: RTL and testbench

Multicycle main control FSM for the 32-bit MIPS-style datapath. It sits directly downstream of the instruction register and consumes its opcode field, instr[31:26]. It also drives that register's load enable `write_ir`, along with every other datapath and memory control signal, using a memory ready handshake for wait states.

---
 rtl/ctrl_pkg.sv | 45 ++++
 rtl/ctrl_fsm_mc.sv | 154 +++++++++++++++
 tb/tb_ctrl_fsm_mc.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle main control FSM: states, opcodes and
// datapath mux/ALU select codes.
package ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        R_WB     = 4'd7,
        EXEC_I   = 4'd8,
        I_WB     = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        ILLEGAL  = 4'd12
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;

    localparam logic [SEL_W-1:0] SRCB_B       = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [SEL_W-1:0] ALU_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALU_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALU_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] PC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/ctrl_fsm_mc.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/write-back
// and drives every datapath and memory control, stalling on mem_ready.
module ctrl_fsm_mc
    import ctrl_pkg::*;
#(
    parameter int unsigned OPC_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OPC_W-1:0]   opcode,
    input  logic               mem_ready,
    output logic               write_ir,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [SEL_W-1:0]   alu_src_b,
    output logic [SEL_W-1:0]   alu_op,
    output logic [SEL_W-1:0]   pc_source,
    output logic               illegal_instr,
    output logic [STATE_W-1:0] state_dbg
);

    localparam logic [OPC_W-1:0] OPC_RTYPE = OPC_W'(OP_RTYPE);
    localparam logic [OPC_W-1:0] OPC_LW    = OPC_W'(OP_LW);
    localparam logic [OPC_W-1:0] OPC_SW    = OPC_W'(OP_SW);
    localparam logic [OPC_W-1:0] OPC_ADDI  = OPC_W'(OP_ADDI);
    localparam logic [OPC_W-1:0] OPC_BEQ   = OPC_W'(OP_BEQ);
    localparam logic [OPC_W-1:0] OPC_J     = OPC_W'(OP_J);

    state_t state_q;
    state_t state_d;

    // Async reset lands in FETCH, so the reset-time outputs fall out of FETCH decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        write_ir      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
        pc_source     = PC_ALU;
        illegal_instr = 1'b0;

        unique case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                // IR and PC load only on the completing cycle, never under reset.
                write_ir  = mem_ready & ~reset;
                pc_write  = mem_ready & ~reset;
                if (mem_ready) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                case (opcode)
                    OPC_RTYPE:      state_d = EXEC_R;
                    OPC_LW, OPC_SW: state_d = MEM_ADDR;
                    OPC_ADDI:       state_d = EXEC_I;
                    OPC_BEQ:        state_d = BRANCH;
                    OPC_J:          state_d = JUMP;
                    default:        state_d = ILLEGAL;
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode == OPC_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_d = MEM_WB;
                end
            end
            MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    state_d = FETCH;
                end
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_d   = R_WB;
            end
            R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = I_WB;
            end
            I_WB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_ALUOUT;
                state_d       = FETCH;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = PC_JUMP;
                state_d   = FETCH;
            end
            ILLEGAL: begin
                illegal_instr = 1'b1;
                state_d       = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_ctrl_fsm_mc.sv
// Bench for ctrl_fsm_mc: directed vector table, randomized instruction stream
// against a per-opcode step-sequence model, and async reset corner cases.
module tb_ctrl_fsm_mc;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       write_ir, pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_instr;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state_dbg;

    typedef struct packed {
        logic       write_ir;
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_instr;
    } ctrl_t;

    typedef struct {
        logic [5:0] opc;
        logic       rdy;
        int         exp_state;
    } vec_t;

    ctrl_t got;
    vec_t  vecs[$];
    int    errors = 0;
    int    checks = 0;

    assign got = {write_ir, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                  pc_source, illegal_instr};

    ctrl_fsm_mc #(.OPC_W(6)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .write_ir(write_ir), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_instr(illegal_instr), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word each state must present, straight from the state output list.
    function automatic ctrl_t exp_ctrl(input int st, input logic rdy);
        ctrl_t c;
        c = '0;
        case (st)
            0:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.write_ir = rdy; c.pc_write = rdy; end
            1:  c.alu_src_b = 2'b11;
            2:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            3:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
            4:  begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
            5:  begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
            6:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            7:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
            8:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            9:  c.reg_write = 1'b1;
            10: begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1; c.pc_source = 2'b01; end
            11: begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
            12: c.illegal_instr = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic step_check(input string tag, input int st, input logic rdy);
        check({tag, " state"}, 32'(state_dbg), 32'(st));
        check({tag, " ctrl"}, 32'(got), 32'(exp_ctrl(st, rdy)));
    endtask

    task automatic add(input logic [5:0] opc, input logic rdy, input int st);
        vec_t v;
        v.opc = opc;
        v.rdy = rdy;
        v.exp_state = st;
        vecs.push_back(v);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] opc;
        logic       rdy;
        int         seq[$];
        int         waits;
        int         wir_count;
        int         st;

        // Directed table: R, lw with MEM_RD waits, sw, beq, illegal, addi, j.
        add(6'h00, 1'b1, 0); add(6'h00, 1'b1, 1); add(6'h3F, 1'b0, 6); add(6'h15, 1'b1, 7);
        add(6'h23, 1'b1, 0); add(6'h23, 1'b1, 1); add(6'h23, 1'b0, 2);
        add(6'h3F, 1'b0, 3); add(6'h3F, 1'b0, 3); add(6'h00, 1'b1, 3); add(6'h23, 1'b1, 4);
        add(6'h2B, 1'b0, 0); add(6'h2B, 1'b1, 0); add(6'h2B, 1'b1, 1); add(6'h2B, 1'b1, 2);
        add(6'h2B, 1'b1, 5);
        add(6'h04, 1'b1, 0); add(6'h04, 1'b1, 1); add(6'h04, 1'b1, 10);
        add(6'h3F, 1'b1, 0); add(6'h3F, 1'b1, 1); add(6'h3F, 1'b1, 12);
        add(6'h08, 1'b1, 0); add(6'h08, 1'b1, 1); add(6'h08, 1'b0, 8); add(6'h08, 1'b1, 9);
        add(6'h02, 1'b1, 0); add(6'h02, 1'b1, 1); add(6'h02, 1'b1, 11);

        reset     = 1'b1;
        mem_ready = 1'b1;
        opcode    = 6'h00;
        #2;
        check("reset state_dbg", 32'(state_dbg), 32'd0);
        check("reset write_ir", 32'(write_ir), 32'd0);
        check("reset ctrl", 32'(got), 32'(exp_ctrl(0, 1'b0)));
        next_cycle();
        next_cycle();
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            opcode    = vecs[i].opc;
            mem_ready = vecs[i].rdy;
            @(negedge clk);
            step_check($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].rdy);
            if (i == 0) check("first fetch write_ir", 32'(write_ir), 32'd1);
            next_cycle();
        end

        // Random instruction stream; the model is each opcode's step list.
        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 6))
                0: opc = 6'h00;
                1: opc = 6'h23;
                2: opc = 6'h2B;
                3: opc = 6'h08;
                4: opc = 6'h04;
                5: opc = 6'h02;
                default: begin
                    opc = 6'($urandom);
                    while (opc inside {6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h02})
                        opc = 6'($urandom);
                end
            endcase
            seq.delete();
            seq.push_back(0);
            seq.push_back(1);
            case (opc)
                6'h00: begin seq.push_back(6); seq.push_back(7); end
                6'h23: begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
                6'h2B: begin seq.push_back(2); seq.push_back(5); end
                6'h08: begin seq.push_back(8); seq.push_back(9); end
                6'h04: seq.push_back(10);
                6'h02: seq.push_back(11);
                default: seq.push_back(12);
            endcase
            wir_count = 0;
            for (int s = 0; s < seq.size(); s++) begin
                st    = seq[s];
                waits = (st == 0 || st == 3 || st == 5) ? $urandom_range(0, 2) : 0;
                for (int w = 0; w <= waits; w++) begin
                    if (st == 0 || st == 3 || st == 5) rdy = (w == waits);
                    else rdy = 1'($urandom_range(0, 1));
                    opcode    = (st == 1 || st == 2) ? opc : 6'($urandom);
                    mem_ready = rdy;
                    @(negedge clk);
                    step_check($sformatf("rnd%0d op%0h", n, opc), st, rdy);
                    if (write_ir) wir_count++;
                    next_cycle();
                end
            end
            check($sformatf("rnd%0d write_ir count", n), 32'(wir_count), 32'd1);
        end

        // Async reset while a store strobe is held.
        opcode    = 6'h2B;
        mem_ready = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        mem_ready = 1'b0;
        @(negedge clk);
        check("mem_wr strobe before reset", 32'(mem_write), 32'd1);
        #1;
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("reset drops mem_write", 32'(mem_write), 32'd0);
        check("reset state_dbg mid-op", 32'(state_dbg), 32'd0);
        check("reset ctrl mid-op", 32'(got), 32'(exp_ctrl(0, 1'b0)));
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        step_check("post-reset fetch", 0, 1'b1);
        next_cycle();
        opcode = 6'h00;
        @(negedge clk);
        step_check("post-reset decode", 1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
